lfsr_period_checker: RTL and testbench
======================================

LFSR_PERIOD_CHECKER -- requirements
Module: lfsr_period_checker

Interface
REQ-001 Parameter WIDTH, default 3: pattern width, matching the upstream lfsr output.
REQ-002 Parameter PERIOD_W, default 4: period counter width; MAX_COUNT = 2^PERIOD_W - 1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  begin or restart a measurement; level sampled each clock.
REQ-006 sample_en  input  1  pattern_in is a new LFSR state this cycle.
REQ-007 pattern_in  input  WIDTH  LFSR state from upstream lfsr.
REQ-008 busy  output  1  high in ARM or MEASURE.
REQ-009 done  output  1  high in DONE; held until start or reset.
REQ-010 period  output  PERIOD_W  measured period in samples; 0 on timeout.
REQ-011 maximal  output  1  done and period == 2^WIDTH - 1.
REQ-012 locked_up  output  1  done and period == 1 (stuck state, e.g. XNOR all-ones).
REQ-013 timeout  output  1  done with no repeat within MAX_COUNT samples.
REQ-014 signature  output  WIDTH  MISR signature over the measured samples.

Function
REQ-015 FSM states IDLE, ARM, MEASURE, DONE, registered; all outputs registered.
REQ-016 IDLE: start=1 -> ARM; otherwise stay.
REQ-017 ARM: clears count, period, signature and flags; on first sample_en, seed <= pattern_in, signature <= pattern_in, count <= 0, -> MEASURE.
REQ-018 MEASURE, per sample_en: count <= count+1; signature <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ pattern_in.
REQ-019 MEASURE: if pattern_in == seed on a sample, period <= count+1, flags set per REQ-011/012, -> DONE on the same edge.
REQ-020 MEASURE: if sample is non-matching and count+1 == MAX_COUNT, timeout <= 1, period <= 0, -> DONE.
REQ-021 Cycles with sample_en=0 SHALL change neither count nor signature, in any state.
REQ-022 start=1 in ARM, MEASURE or DONE SHALL -> ARM; outputs cleared per REQ-017. start takes priority over a simultaneous match or timeout.
REQ-023 done, maximal, locked_up and timeout SHALL be visible the cycle after the deciding sample edge (latency 1).
REQ-024 period, signature and flags SHALL be held stable in DONE; the signature includes the closing (matching) sample.
REQ-025 Count arithmetic is unsigned PERIOD_W bits and SHALL never wrap (bounded by REQ-020).

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, and busy, done, period, maximal, locked_up, timeout, signature, seed and count to 0.
REQ-027 Deassertion of reset mid-measurement SHALL leave the block in IDLE; a new start is required.

Verification
REQ-028 Maximal sequence: start, then samples 000,001,010,101,011,110,100,000 -> done=1, period=7, maximal=1, signature=010.
REQ-029 Lockup: start, then samples 111,111 -> done=1, period=1, locked_up=1, maximal=0, signature=000.
REQ-030 Timeout: start, seed 000, then 15 samples of 001 -> done=1, timeout=1, period=0.
REQ-031 Gapped input: the REQ-028 stream with sample_en=0 for 2 cycles between each sample -> identical results to REQ-028.
REQ-032 Restart and reset: start asserted after 3 samples of the REQ-028 stream, then the stream from 001 -> seed 001, period=7. Separately, reset=0 mid-MEASURE -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/lfsr_period_checker.sv
// LFSR period checker: measures the repeat distance of an upstream
// LFSR stream, flags maximal/lockup/timeout and keeps a MISR signature.
module lfsr_period_checker #(
  parameter int WIDTH    = 3,
  parameter int PERIOD_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sample_en,
  input  logic [WIDTH-1:0]    pattern_in,
  output logic                busy,
  output logic                done,
  output logic [PERIOD_W-1:0] period,
  output logic                maximal,
  output logic                locked_up,
  output logic                timeout,
  output logic [WIDTH-1:0]    signature
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [PERIOD_W-1:0] MAX_COUNT = '1;
  localparam logic [PERIOD_W-1:0] MAX_PER   =
    PERIOD_W'((1 << WIDTH) - 1);
  localparam logic [PERIOD_W-1:0] ONE       = PERIOD_W'(1);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_count;
  logic [PERIOD_W-1:0] r_period;
  logic [WIDTH-1:0]    r_seed;
  logic [WIDTH-1:0]    r_sig;
  logic                r_busy;
  logic                r_done;
  logic                r_max;
  logic                r_lock;
  logic                r_to;

  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]    w_sig_nxt;
  logic                w_match;
  logic                w_limit;

  // Next count, rotated signature and decision terms for a sample.
  always_comb begin
    w_cnt_nxt = r_count + ONE;
    w_sig_nxt = {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ pattern_in;
    w_match   = (pattern_in == r_seed);
    w_limit   = (w_cnt_nxt == MAX_COUNT);
  end

  // Measurement FSM; start overrides any decision on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_seed   <= '0;
      r_sig    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_max    <= 1'b0;
      r_lock   <= 1'b0;
      r_to     <= 1'b0;
    end else if (start) begin
      r_state  <= ARM;
      r_count  <= '0;
      r_period <= '0;
      r_seed   <= '0;
      r_sig    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_max    <= 1'b0;
      r_lock   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        ARM: begin
          if (sample_en) begin
            r_seed  <= pattern_in;
            r_sig   <= pattern_in;
            r_count <= '0;
            r_state <= MEASURE;
          end
        end
        MEASURE: begin
          if (sample_en) begin
            r_count <= w_cnt_nxt;
            r_sig   <= w_sig_nxt;
            if (w_match) begin
              r_period <= w_cnt_nxt;
              r_max    <= (w_cnt_nxt == MAX_PER);
              r_lock   <= (w_cnt_nxt == ONE);
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end else if (w_limit) begin
              r_period <= '0;
              r_to     <= 1'b1;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign period    = r_period;
  assign maximal   = r_max;
  assign locked_up = r_lock;
  assign timeout   = r_to;
  assign signature = r_sig;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Scoreboard bench for lfsr_period_checker: stimulus pushes expected
// results, a negedge monitor pops them when done rises.
module tb_lfsr_period_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sample_en;
  logic [2:0] pattern_in;
  logic       busy;
  logic       done;
  logic [3:0] period;
  logic       maximal;
  logic       locked_up;
  logic       timeout;
  logic [2:0] signature;

  typedef struct {
    logic [3:0] per;
    logic       mx;
    logic       lk;
    logic       to;
    logic [2:0] sig;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;
  int   cyc  = 0;
  int   drv_cyc = 0;
  logic prev_done = 1'b0;

  logic [2:0] stream [8] = '{3'd0, 3'd1, 3'd2, 3'd5,
                             3'd3, 3'd6, 3'd4, 3'd0};

  lfsr_period_checker #(.WIDTH(3), .PERIOD_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sample_en(sample_en),
    .pattern_in(pattern_in),
    .busy(busy),
    .done(done),
    .period(period),
    .maximal(maximal),
    .locked_up(locked_up),
    .timeout(timeout),
    .signature(signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nbad = nbad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on each rising done.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done && !prev_done) begin
      if (q.size() == 0) begin
        cmp("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        cmp("period", int'(period), int'(e.per));
        cmp("maximal", int'(maximal), int'(e.mx));
        cmp("locked_up", int'(locked_up), int'(e.lk));
        cmp("timeout", int'(timeout), int'(e.to));
        cmp("signature", int'(signature), int'(e.sig));
        cmp("done_latency_cyc", cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] p, input int gap);
    @(negedge clk);
    sample_en  = 1'b1;
    pattern_in = p;
    drv_cyc    = cyc;
    if (gap > 0) begin
      @(negedge clk);
      sample_en = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic push(input logic [3:0] per, input logic mx,
                      input logic lk, input logic to,
                      input logic [2:0] sig);
    exp_t e;
    e.per = per;
    e.mx  = mx;
    e.lk  = lk;
    e.to  = to;
    e.sig = sig;
    e.cyc = drv_cyc + 1;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n = n + 1;
    end
    if (q.size() != 0) begin
      cmp("done_wait_budget", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    sample_en  = 1'b0;
    pattern_in = 3'd0;
    repeat (3) @(negedge clk);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    cmp("rst_period", int'(period), 0);
    cmp("rst_flags", int'({maximal, locked_up, timeout}), 0);
    cmp("rst_signature", int'(signature), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Maximal 7-state stream, back to back.
    do_start();
    cmp("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 7; i++) send(stream[i], 0);
    send(stream[7], 0);
    push(4'd7, 1'b1, 1'b0, 1'b0, 3'b010);
    idle();
    drain();
    repeat (3) @(negedge clk);
    cmp("hold_done", int'(done), 1);
    cmp("hold_period", int'(period), 7);
    cmp("hold_signature", int'(signature), 2);
    cmp("busy_in_done", int'(busy), 0);

    // Lockup on a stuck all-ones state.
    do_start();
    cmp("start_clears_done", int'(done), 0);
    send(3'b111, 0);
    send(3'b111, 0);
    push(4'd1, 1'b0, 1'b1, 1'b0, 3'b000);
    idle();
    drain();

    // Timeout: seed 000 then 15 samples of 001, never repeating.
    do_start();
    send(3'b000, 0);
    for (int i = 0; i < 14; i++) send(3'b001, 0);
    send(3'b001, 0);
    push(4'd0, 1'b0, 1'b0, 1'b1, 3'b111);
    idle();
    drain();

    // Gapped stream: two idle cycles between samples.
    do_start();
    for (int i = 0; i < 7; i++) send(stream[i], 2);
    send(stream[7], 0);
    push(4'd7, 1'b1, 1'b0, 1'b0, 3'b010);
    idle();
    drain();

    // Restart mid-measurement, then stream from 001.
    do_start();
    for (int i = 0; i < 3; i++) send(stream[i], 0);
    idle();
    do_start();
    for (int i = 1; i < 8; i++) send(stream[i], 0);
    send(3'b001, 0);
    push(4'd7, 1'b1, 1'b0, 1'b0, 3'b101);
    idle();
    drain();

    // Asynchronous reset in MEASURE.
    do_start();
    send(3'b000, 0);
    send(3'b001, 0);
    send(3'b010, 0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    cmp("amid_busy", int'(busy), 0);
    cmp("amid_signature", int'(signature), 0);
    cmp("amid_period", int'(period), 0);
    @(negedge clk);
    reset = 1'b1;
    send(3'b000, 0);
    send(3'b000, 0);
    idle();
    repeat (2) @(negedge clk);
    cmp("post_rst_busy", int'(busy), 0);
    cmp("post_rst_done", int'(done), 0);
    cmp("post_rst_signature", int'(signature), 0);
    cmp("leftover_expect", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
